// File: rtl/dpram_dma.sv
// Block-transfer initiator for one port of the dual-port RAM: constant fill
// and ascending forward copy, driven by a start/done command interface.
`timescale 1ns/1ps
module dpram_dma #(
   parameter int data_width_g = 8,
   parameter int addr_width_g = 14
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    mode,
   input  logic [addr_width_g-1:0] src,
   input  logic [addr_width_g-1:0] dst,
   input  logic [addr_width_g:0]   len,
   input  logic [data_width_g-1:0] fill_value,
   input  logic                    abort,
   output logic                    busy,
   output logic                    done,
   output logic                    ram_cs,
   output logic                    wren,
   output logic [addr_width_g-1:0] address,
   output logic [data_width_g-1:0] data,
   input  logic [data_width_g-1:0] q
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_FILL = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [addr_width_g-1:0] addr_zero_c = {addr_width_g{1'b0}};
   localparam logic [addr_width_g-1:0] addr_one_c  = {{(addr_width_g-1){1'b0}}, 1'b1};
   localparam logic [addr_width_g:0]   rem_zero_c  = {(addr_width_g+1){1'b0}};
   localparam logic [addr_width_g:0]   rem_one_c   = {{addr_width_g{1'b0}}, 1'b1};
   localparam logic [data_width_g-1:0] data_zero_c = {data_width_g{1'b0}};

   state_t                  state_r, state_nx_s;
   logic [addr_width_g-1:0] src_ptr_r, src_nx_s;
   logic [addr_width_g-1:0] dst_ptr_r, dst_nx_s;
   logic [addr_width_g:0]   remaining_r, rem_nx_s;
   logic [data_width_g-1:0] value_r, value_nx_s;
   logic [addr_width_g-1:0] address_r, address_nx_s;
   logic [data_width_g-1:0] data_r, data_nx_s;
   logic                    ram_cs_r, wren_r, busy_r, done_r;
   logic                    ram_cs_nx_s, wren_nx_s, busy_nx_s, done_nx_s;

   // Next-state and operand bookkeeping; abort overrides any active transition.
   always_comb begin
      state_nx_s = state_r;
      src_nx_s   = src_ptr_r;
      dst_nx_s   = dst_ptr_r;
      rem_nx_s   = remaining_r;
      value_nx_s = value_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               src_nx_s   = src;
               dst_nx_s   = dst;
               rem_nx_s   = len;
               value_nx_s = fill_value;
               if (len == rem_zero_c) begin
                  state_nx_s = ST_DONE;
               end else if (mode == 1'b0) begin
                  state_nx_s = ST_RD;
               end else begin
                  state_nx_s = ST_FILL;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_RD: begin
            if (abort) begin
               state_nx_s = ST_IDLE;
            end else begin
               src_nx_s   = src_ptr_r + addr_one_c;
               state_nx_s = ST_WR;
            end
         end
         ST_WR, ST_FILL: begin
            if (abort) begin
               state_nx_s = ST_IDLE;
            end else begin
               dst_nx_s = dst_ptr_r + addr_one_c;
               rem_nx_s = remaining_r - rem_one_c;
               if (remaining_r == rem_one_c) begin
                  state_nx_s = ST_DONE;
               end else if (state_r == ST_WR) begin
                  state_nx_s = ST_RD;
               end else begin
                  state_nx_s = ST_FILL;
               end
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // Output values for the coming cycle, derived from the next state so the
   // ports come straight from flops.
   always_comb begin
      ram_cs_nx_s  = 1'b0;
      wren_nx_s    = 1'b0;
      busy_nx_s    = (state_nx_s != ST_IDLE);
      done_nx_s    = (state_nx_s == ST_DONE);
      address_nx_s = address_r;
      data_nx_s    = data_r;
      case (state_nx_s)
         ST_RD: begin
            ram_cs_nx_s  = 1'b1;
            address_nx_s = src_nx_s;
         end
         ST_WR: begin
            ram_cs_nx_s  = 1'b1;
            wren_nx_s    = 1'b1;
            address_nx_s = dst_nx_s;
         end
         ST_FILL: begin
            ram_cs_nx_s  = 1'b1;
            wren_nx_s    = 1'b1;
            address_nx_s = dst_nx_s;
            data_nx_s    = value_nx_s;
         end
         default: begin
            ram_cs_nx_s = 1'b0;
         end
      endcase
      // Keep the copied word once WR ends so data holds its last value.
      if (state_r == ST_WR) begin
         data_nx_s = q;
      end else begin
         data_nx_s = data_nx_s;
      end
   end

   // State, operand and output registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         src_ptr_r   <= addr_zero_c;
         dst_ptr_r   <= addr_zero_c;
         remaining_r <= rem_zero_c;
         value_r     <= data_zero_c;
         address_r   <= addr_zero_c;
         data_r      <= data_zero_c;
         ram_cs_r    <= 1'b0;
         wren_r      <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         src_ptr_r   <= src_nx_s;
         dst_ptr_r   <= dst_nx_s;
         remaining_r <= rem_nx_s;
         value_r     <= value_nx_s;
         address_r   <= address_nx_s;
         data_r      <= data_nx_s;
         ram_cs_r    <= ram_cs_nx_s;
         wren_r      <= wren_nx_s;
         busy_r      <= busy_nx_s;
         done_r      <= done_nx_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign ram_cs  = ram_cs_r;
   assign wren    = wren_r;
   assign address = address_r;
   // The RAM's registered read word feeds straight through during WR.
   assign data    = (state_r == ST_WR) ? q : data_r;

endmodule

// File: tb/tb_dpram_dma.sv
// Directed bench for dpram_dma with a behavioural synchronous RAM model
// (one-cycle read latency, read-before-write).
`timescale 1ns/1ps
module tb_dpram_dma;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [13:0] src = 14'h0000;
   logic [13:0] dst = 14'h0000;
   logic [14:0] len = 15'h0000;
   logic [7:0]  fill_value = 8'h00;
   logic        abort = 1'b0;
   logic        busy, done, ram_cs, wren;
   logic [13:0] address;
   logic [7:0]  data;
   logic [7:0]  q = 8'h00;

   logic [7:0]  mem [0:16383];

   logic        log_cs   [0:31];
   logic        log_wren [0:31];
   logic        log_busy [0:31];
   logic        log_done [0:31];
   logic [13:0] log_addr [0:31];
   logic [7:0]  log_data [0:31];

   logic [7:0]  cp_exp [0:2];

   int total = 0;
   int bad   = 0;

   dpram_dma #(.data_width_g(8), .addr_width_g(14)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
      .src(src), .dst(dst), .len(len), .fill_value(fill_value),
      .abort(abort), .busy(busy), .done(done), .ram_cs(ram_cs),
      .wren(wren), .address(address), .data(data), .q(q)
   );

   always #5 clock = ~clock;

   // RAM port model: registered read, old contents returned on a write.
   always @(posedge clock) begin
      if (ram_cs) begin
         q <= mem[address];
         if (wren) mem[address] <= data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Issue one command, then log outputs at the falling edge of cycles 1..n.
   task automatic run_cmd(input logic m, input logic [13:0] s, input logic [13:0] d,
                          input logic [14:0] l, input logic [7:0] fv, input int n,
                          input int abort_at, input int restart_at);
      @(negedge clock);
      mode = m; src = s; dst = d; len = l; fill_value = fv; start = 1'b1;
      @(posedge clock);
      for (int k = 1; k <= n; k++) begin
         @(negedge clock);
         log_cs[k]   = ram_cs;
         log_wren[k] = wren;
         log_busy[k] = busy;
         log_done[k] = done;
         log_addr[k] = address;
         log_data[k] = data;
         abort = (k == abort_at);
         if (k == restart_at) begin
            mode = 1'b0; src = 14'h0000; dst = 14'h0200; len = 15'h0002;
            fill_value = 8'hFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
      cp_exp[0] = 8'h11; cp_exp[1] = 8'h22; cp_exp[2] = 8'h33;

      // Reset values
      #1;
      check_eq("rst_busy", 32'(busy), 32'h0);
      check_eq("rst_done", 32'(done), 32'h0);
      check_eq("rst_cs", 32'(ram_cs), 32'h0);
      check_eq("rst_wren", 32'(wren), 32'h0);
      check_eq("rst_addr", 32'(address), 32'h0);
      check_eq("rst_data", 32'(data), 32'h0);
      @(negedge clock); @(negedge clock);
      reset_n = 1'b1;

      // Fill 4 x A5 at 0x0010
      run_cmd(1'b1, 14'h0000, 14'h0010, 15'h0004, 8'hA5, 6, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         check_eq($sformatf("fill_cs%0d", k), 32'(log_cs[k]), 32'h1);
         check_eq($sformatf("fill_wren%0d", k), 32'(log_wren[k]), 32'h1);
         check_eq($sformatf("fill_addr%0d", k), 32'(log_addr[k]), 32'(15 + k));
         check_eq($sformatf("fill_data%0d", k), 32'(log_data[k]), 32'hA5);
      end
      for (int k = 1; k <= 6; k++) begin
         check_eq($sformatf("fill_done%0d", k), 32'(log_done[k]), 32'(k == 5));
         check_eq($sformatf("fill_busy%0d", k), 32'(log_busy[k]), 32'(k <= 5));
      end
      check_eq("fill_cs5", 32'(log_cs[5]), 32'h0);
      for (int i = 0; i < 4; i++) check_eq($sformatf("fill_mem%0d", i), 32'(mem[16 + i]), 32'hA5);

      // Copy 3 words 0x0010 -> 0x0100
      mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33;
      run_cmd(1'b0, 14'h0010, 14'h0100, 15'h0003, 8'h00, 8, 0, 0);
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("cp_rd_cs%0d", i), 32'(log_cs[2*i+1]), 32'h1);
         check_eq($sformatf("cp_rd_wren%0d", i), 32'(log_wren[2*i+1]), 32'h0);
         check_eq($sformatf("cp_rd_addr%0d", i), 32'(log_addr[2*i+1]), 32'(16 + i));
         check_eq($sformatf("cp_wr_wren%0d", i), 32'(log_wren[2*i+2]), 32'h1);
         check_eq($sformatf("cp_wr_addr%0d", i), 32'(log_addr[2*i+2]), 32'(256 + i));
         check_eq($sformatf("cp_wr_data%0d", i), 32'(log_data[2*i+2]), 32'(cp_exp[i]));
         check_eq($sformatf("cp_mem%0d", i), 32'(mem[256 + i]), 32'(cp_exp[i]));
      end
      for (int k = 1; k <= 8; k++) check_eq($sformatf("cp_done%0d", k), 32'(log_done[k]), 32'(k == 7));
      check_eq("cp_busy8", 32'(log_busy[8]), 32'h0);

      // Wrap-around fill
      run_cmd(1'b1, 14'h0000, 14'h3FFF, 15'h0002, 8'h5A, 4, 0, 0);
      check_eq("wrap_addr1", 32'(log_addr[1]), 32'h3FFF);
      check_eq("wrap_addr2", 32'(log_addr[2]), 32'h0000);
      check_eq("wrap_done3", 32'(log_done[3]), 32'h1);
      check_eq("wrap_mem_hi", 32'(mem[16383]), 32'h5A);
      check_eq("wrap_mem_lo", 32'(mem[0]), 32'h5A);

      // Zero length
      run_cmd(1'b0, 14'h0000, 14'h0050, 15'h0000, 8'h00, 3, 0, 0);
      check_eq("zero_done1", 32'(log_done[1]), 32'h1);
      check_eq("zero_busy1", 32'(log_busy[1]), 32'h1);
      check_eq("zero_done2", 32'(log_done[2]), 32'h0);
      check_eq("zero_busy2", 32'(log_busy[2]), 32'h0);
      for (int k = 1; k <= 3; k++) check_eq($sformatf("zero_cs%0d", k), 32'(log_cs[k]), 32'h0);

      // Second start during a fill is ignored
      run_cmd(1'b1, 14'h0000, 14'h0030, 15'h0004, 8'hC3, 7, 0, 2);
      for (int k = 1; k <= 4; k++) begin
         check_eq($sformatf("ign_addr%0d", k), 32'(log_addr[k]), 32'(47 + k));
         check_eq($sformatf("ign_data%0d", k), 32'(log_data[k]), 32'hC3);
      end
      check_eq("ign_done5", 32'(log_done[5]), 32'h1);
      check_eq("ign_busy6", 32'(log_busy[6]), 32'h0);
      check_eq("ign_cs7", 32'(log_cs[7]), 32'h0);
      check_eq("ign_mem200", 32'(mem[512]), 32'h00);
      check_eq("ign_mem33", 32'(mem[51]), 32'hC3);

      // Overlapping copy replicates the first word
      mem[32] = 8'h01; mem[33] = 8'h02;
      run_cmd(1'b0, 14'h0020, 14'h0021, 15'h0003, 8'h00, 8, 0, 0);
      for (int i = 0; i < 3; i++) check_eq($sformatf("ovl_mem%0d", i), 32'(mem[33 + i]), 32'h01);
      check_eq("ovl_done7", 32'(log_done[7]), 32'h1);

      // Abort in the second WR of an 8-word copy
      for (int i = 0; i < 8; i++) mem[64 + i] = 8'(8'h80 + i);
      run_cmd(1'b0, 14'h0040, 14'h0060, 15'h0008, 8'h00, 6, 4, 0);
      check_eq("abt_mem0", 32'(mem[96]), 32'h80);
      check_eq("abt_mem1", 32'(mem[97]), 32'h81);
      check_eq("abt_mem2", 32'(mem[98]), 32'h00);
      check_eq("abt_busy5", 32'(log_busy[5]), 32'h0);
      check_eq("abt_cs5", 32'(log_cs[5]), 32'h0);
      for (int k = 1; k <= 6; k++) check_eq($sformatf("abt_done%0d", k), 32'(log_done[k]), 32'h0);

      // Asynchronous reset mid-fill
      @(negedge clock);
      mode = 1'b1; dst = 14'h0070; len = 15'h0008; fill_value = 8'h77; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check_eq("ar_cs_pre", 32'(ram_cs), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      check_eq("ar_cs", 32'(ram_cs), 32'h0);
      check_eq("ar_wren", 32'(wren), 32'h0);
      check_eq("ar_busy", 32'(busy), 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      check_eq("ar_mem70", 32'(mem[112]), 32'h77);
      check_eq("ar_mem71", 32'(mem[113]), 32'h00);
      run_cmd(1'b1, 14'h0000, 14'h0080, 15'h0002, 8'h99, 4, 0, 0);
      check_eq("ar_done3", 32'(log_done[3]), 32'h1);
      check_eq("ar_mem80", 32'(mem[128]), 32'h99);
      check_eq("ar_mem81", 32'(mem[129]), 32'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
